fp_addsub_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor, successor to the single-precision `floatadder`. Exponent and mantissa widths are parameters, and an add/subtract mode is selected per operation. Results are rounded to nearest-even and carry exception flags. A valid/ready handshake with backpressure lets the block sit directly in the processor's execute-stage FP path.

---
 rtl/fp_addsub_pipe_if.sv | 27 ++
 rtl/fp_addsub_pipe.sv | 167 ++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_pipe_if.sv
// rtl/fp_addsub_pipe_if.sv - operand/result handshake bundle for fp_addsub_pipe
interface fp_addsub_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - three-stage parametrised FP add/sub, round-to-nearest-even
// S1 unpack/swap/align, S2 add/sub, S3 normalise/round/pack; all stages freeze on stall.
module fp_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic            clk,
   input  logic            rst_n,
   fp_addsub_pipe_if.slave io
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int FW  = MAN_W + 4;
   localparam int XW  = EXP_W + $clog2(FW) + 2;
   localparam int LZW = $clog2(FW + 1);
   localparam int MRW = MAN_W + 2;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic adv;

   logic             v1_q, v1_d, sp1_q, sp1_d, sx1_q, sx1_d, es1_q, es1_d;
   logic [W-1:0]     spr1_q, spr1_d;
   logic [3:0]       spf1_q, spf1_d;
   logic [EXP_W-1:0] ex1_q, ex1_d;
   logic [FW-1:0]    mx1_q, mx1_d, my1_q, my1_d;

   logic             v2_q, v2_d, sp2_q, sp2_d, sx2_q, sx2_d, es2_q, es2_d;
   logic [W-1:0]     spr2_q, spr2_d;
   logic [3:0]       spf2_q, spf2_d;
   logic [EXP_W-1:0] ex2_q, ex2_d;
   logic [FW:0]      sum2_q, sum2_d;

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_big, lost;
   logic [EXP_W-1:0] ea, eb, ey;
   logic [MAN_W-1:0] ma, mb;
   logic [FW-1:0]    my_f;
   logic [31:0]      diff;

   logic [LZW-1:0]   lz;
   logic [FW-1:0]    norm;
   logic [XW-1:0]    ex_n, ex_r;
   logic [MRW-1:0]   mr;
   logic [MAN_W-1:0] man_r;
   logic             inc, inexact, ovf, unf;

   assign adv          = !out_valid_q || io.out_ready;
   assign io.in_ready  = adv;
   assign io.out_valid = out_valid_q;
   assign io.result    = result_q;
   assign io.flags     = flags_q;

   always_comb begin : s1_comb
      sa    = io.a[W-1];
      sb    = io.b[W-1] ^ io.sub;
      ea    = io.a[W-2 -: EXP_W];
      eb    = io.b[W-2 -: EXP_W];
      ma    = io.a[MAN_W-1:0];
      mb    = io.b[MAN_W-1:0];
      a_nan = (&ea) && (ma != '0);
      b_nan = (&eb) && (mb != '0);
      a_inf = (&ea) && (ma == '0);
      b_inf = (&eb) && (mb == '0);
      a_big = io.a[W-2:0] >= io.b[W-2:0];
      v1_d  = io.in_valid;
      sx1_d = a_big ? sa : sb;
      es1_d = sa ^ sb;
      ex1_d = a_big ? ea : eb;
      ey    = a_big ? eb : ea;
      // exp==0 inputs are flushed to zero, so they lose the hidden bit and mantissa
      mx1_d = (ex1_d != '0) ? {1'b1, (a_big ? ma : mb), 3'b000} : '0;
      my_f  = (ey != '0)    ? {1'b1, (a_big ? mb : ma), 3'b000} : '0;
      diff  = 32'(ex1_d) - 32'(ey);
      lost  = 1'b0;
      if (diff >= 32'(FW - 1)) begin
         my1_d = {{(FW-1){1'b0}}, |my_f};
      end else begin
         lost  = |(my_f & ~({FW{1'b1}} << diff));
         my1_d = (my_f >> diff) | {{(FW-1){1'b0}}, lost};
      end
      sp1_d  = a_nan || b_nan || a_inf || b_inf;
      spr1_d = QNAN;
      spf1_d = 4'b0000;
      if (a_nan || b_nan) begin
         spr1_d = QNAN;
      end else if (a_inf && b_inf && (sa != sb)) begin
         spf1_d = 4'b1000;
      end else if (a_inf) begin
         spr1_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spr1_d = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   always_comb begin : s2_comb
      v2_d   = v1_q;
      sp2_d  = sp1_q;
      spr2_d = spr1_q;
      spf2_d = spf1_q;
      sx2_d  = sx1_q;
      es2_d  = es1_q;
      ex2_d  = ex1_q;
      sum2_d = es1_q ? ({1'b0, mx1_q} - {1'b0, my1_q}) : ({1'b0, mx1_q} + {1'b0, my1_q});
   end

   always_comb begin : s3_comb
      out_valid_d = v2_q;
      lz = '0;
      for (int i = 0; i < FW; i++) begin
         if (sum2_q[i]) lz = LZW'(FW - 1 - i);
      end
      if (sum2_q[FW]) begin
         norm = {sum2_q[FW:2], |sum2_q[1:0]};
         ex_n = XW'(ex2_q) + XW'(1);
      end else begin
         norm = sum2_q[FW-1:0] << lz;
         ex_n = XW'(ex2_q) - XW'(lz);
      end
      // norm = {hidden, mantissa, guard, round, sticky}
      inc     = norm[2] & (norm[1] | norm[0] | norm[3]);
      mr      = {1'b0, norm[FW-1:3]} + MRW'(inc);
      inexact = |norm[2:0];
      if (mr[MAN_W+1]) begin
         ex_r  = ex_n + XW'(1);
         man_r = mr[MAN_W:1];
      end else begin
         ex_r  = ex_n;
         man_r = mr[MAN_W-1:0];
      end
      ovf = !ex_r[XW-1] && (ex_r >= XW'(2**EXP_W - 1));
      unf = ex_r[XW-1] || (ex_r == '0);
      if (sp2_q) begin
         result_d = spr2_q;
         flags_d  = spf2_q;
      end else if (sum2_q == '0) begin
         result_d = {(es2_q ? 1'b0 : sx2_q), {(W-1){1'b0}}};
         flags_d  = 4'b0000;
      end else if (ovf) begin
         result_d = {sx2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d  = 4'b0101;
      end else if (unf) begin
         result_d = {sx2_q, {(W-1){1'b0}}};
         flags_d  = 4'b0011;
      end else begin
         result_d = {sx2_q, ex_r[EXP_W-1:0], man_r};
         flags_d  = {3'b000, inexact};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0; sp1_q <= 1'b0; sx1_q <= 1'b0; es1_q <= 1'b0;
         spr1_q <= '0; spf1_q <= '0; ex1_q <= '0; mx1_q <= '0; my1_q <= '0;
         v2_q <= 1'b0; sp2_q <= 1'b0; sx2_q <= 1'b0; es2_q <= 1'b0;
         spr2_q <= '0; spf2_q <= '0; ex2_q <= '0; sum2_q <= '0;
         out_valid_q <= 1'b0; result_q <= '0; flags_q <= '0;
      end else if (adv) begin
         v1_q <= v1_d; sp1_q <= sp1_d; sx1_q <= sx1_d; es1_q <= es1_d;
         spr1_q <= spr1_d; spf1_q <= spf1_d; ex1_q <= ex1_d; mx1_q <= mx1_d; my1_q <= my1_d;
         v2_q <= v2_d; sp2_q <= sp2_d; sx2_q <= sx2_d; es2_q <= es2_d;
         spr2_q <= spr2_d; spf2_q <= spf2_d; ex2_q <= ex2_d; sum2_q <= sum2_d;
         out_valid_q <= out_valid_d; result_q <= result_d; flags_q <= flags_d;
      end
   end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - scoreboard bench for fp_addsub_pipe (single and half-width instances)
module tb_fp_addsub_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) sif ();
   fp_addsub_pipe_if #(.EXP_W(5), .MAN_W(10)) hif ();

   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut_sp (.clk(clk), .rst_n(rst_n), .io(sif));
   fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_hp (.clk(clk), .rst_n(rst_n), .io(hif));

   int checks = 0;
   int passed = 0;
   int acc_cnt = 0;
   logic [31:0] sq_res[$];
   logic [3:0]  sq_flg[$];
   logic [15:0] hq_res[$];
   logic [3:0]  hq_flg[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && sif.in_valid && sif.in_ready) acc_cnt++;
   end

   always @(negedge clk) begin
      if (rst_n && sif.out_valid && sif.out_ready) begin
         check("sp_out_expected", {31'b0, sq_res.size() != 0}, 32'd1);
         if (sq_res.size() != 0) begin
            check("sp_result", sif.result, sq_res.pop_front());
            check("sp_flags", {28'b0, sif.flags}, {28'b0, sq_flg.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && hif.out_valid && hif.out_ready) begin
         check("hp_out_expected", {31'b0, hq_res.size() != 0}, 32'd1);
         if (hq_res.size() != 0) begin
            check("hp_result", {16'b0, hif.result}, {16'b0, hq_res.pop_front()});
            check("hp_flags", {28'b0, hif.flags}, {28'b0, hq_flg.pop_front()});
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] er, input logic [3:0] ef);
      int n;
      sif.in_valid = 1'b1; sif.a = a; sif.b = b; sif.sub = sub;
      n = 0;
      @(negedge clk);
      while (!sif.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("sp_in_ready_wait", {31'b0, sif.in_ready}, 32'd1);
      sq_res.push_back(er);
      sq_flg.push_back(ef);
      @(posedge clk);
      #1 sif.in_valid = 1'b0;
   endtask

   task automatic send_h(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [15:0] er, input logic [3:0] ef);
      int n;
      hif.in_valid = 1'b1; hif.a = a; hif.b = b; hif.sub = sub;
      n = 0;
      @(negedge clk);
      while (!hif.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("hp_in_ready_wait", {31'b0, hif.in_ready}, 32'd1);
      hq_res.push_back(er);
      hq_flg.push_back(ef);
      @(posedge clk);
      #1 hif.in_valid = 1'b0;
   endtask

   initial begin
      int n;
      int stale;
      sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.sub = 1'b0; sif.out_ready = 1'b1;
      hif.in_valid = 1'b0; hif.a = '0; hif.b = '0; hif.sub = 1'b0; hif.out_ready = 1'b1;
      #12;
      check("rst_out_valid", {31'b0, sif.out_valid}, 32'd0);
      check("rst_result", sif.result, 32'h0);
      check("rst_flags", {28'b0, sif.flags}, 32'h0);
      check("rst_in_ready", {31'b0, sif.in_ready}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // latency: accepted on edge e, visible after edge e+2
      send(32'h3FC00000, 32'h41B80000, 1'b0, 32'h41C40000, 4'b0000);
      @(negedge clk); check("lat_e0", {31'b0, sif.out_valid}, 32'd0);
      @(negedge clk); check("lat_e1", {31'b0, sif.out_valid}, 32'd0);
      @(negedge clk); check("lat_e2", {31'b0, sif.out_valid}, 32'd1);
      @(posedge clk); #1;

      send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
      send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
      send(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
      send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
      send(32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
      send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
      send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
      send(32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 4'b0000);
      send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
      send(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
      send(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
      repeat (5) @(negedge clk);

      // backpressure: consumer stalled from the start
      @(posedge clk); #1;
      sif.out_ready = 1'b0;
      acc_cnt = 0;
      fork
         begin
            send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
            send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000);
            send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);
            send(32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 4'b0000);
            send(32'h40A00000, 32'h3F800000, 1'b0, 32'h40C00000, 4'b0000);
         end
         begin
            n = 0;
            @(negedge clk);
            while (!sif.out_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            check("bp_out_valid_rise", {31'b0, sif.out_valid}, 32'd1);
            check("bp_in_ready_low", {31'b0, sif.in_ready}, 32'd0);
            check("bp_accepted_3", acc_cnt, 32'd3);
            repeat (4) begin
               @(negedge clk);
               check("bp_stall_result", sif.result, 32'h40000000);
               check("bp_stall_valid", {31'b0, sif.out_valid}, 32'd1);
            end
            check("bp_still_3", acc_cnt, 32'd3);
            @(posedge clk); #1;
            sif.out_ready = 1'b1;
         end
      join
      n = 0;
      while (sq_res.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("bp_drained", sq_res.size(), 32'd0);

      // asynchronous reset with three operations in flight
      @(posedge clk); #1;
      send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
      send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000);
      send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'b0, sif.out_valid}, 32'd0);
      check("arst_result", sif.result, 32'h0);
      check("arst_flags", {28'b0, sif.flags}, 32'h0);
      check("arst_in_ready", {31'b0, sif.in_ready}, 32'd1);
      sq_res.delete();
      sq_flg.delete();
      @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (sif.out_valid) stale++;
      end
      check("arst_no_stale", stale, 32'd0);
      @(posedge clk); #1;
      send(32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 4'b0000);

      // narrow format instance
      send_h(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
      send_h(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
      send_h(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
      send_h(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000);

      n = 0;
      while ((sq_res.size() != 0 || hq_res.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("final_drain", sq_res.size() + hq_res.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
